rr_arbiter_8: RTL and testbench
===============================

Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one downstream resource (e.g., a shared bus or encoder datapath) among 8 requesters.
- Sits between the requester bank and the shared resource.
- Emits a one-hot grant vector plus its 3-bit binary index.
- Holds each grant until the owner drops its request, then rotates priority to the next requester.

Parameters:
- N, 8, number of requesters (the design supports only 8; the parameter exists for documentation and checks).
- IDX_W, 3, width of the grant index (log2 N).
- MAX_HOLD, 16, maximum consecutive cycles one grant may be held (used only with ARB_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit i is requester i, level-sensitive.
- grant  output  8  one-hot grant vector, registered; all-zero when idle.
- grant_idx  output  3  binary index of the granted requester, registered; 0 when idle.
- grant_valid  output  1  high while any grant is active (equals OR of grant).

Behaviour:
- Reset (reset_n=0, asynchronous):
  - grant=0, grant_idx=0, grant_valid=0.
  - Internal priority pointer ptr=0, state=IDLE.
  - Reset mid-grant drops the grant immediately, without waiting for a clock edge.
- States: IDLE, BUSY.
- IDLE:
  - If req==0, stay in IDLE with outputs 0.
  - Otherwise pick the winner w: the first set bit of req scanning ptr, ptr+1, … ptr+7, mod 8.
  - Next edge: grant=1<<w, grant_idx=w, grant_valid=1, state=BUSY.
  - Latency from request to grant is 1 cycle.
- BUSY:
  - While req[grant_idx]=1, hold grant unchanged. Other requests are ignored; there is no preemption.
  - When req[grant_idx]=0:
    - ptr := grant_idx+1 (wraps 7→0).
    - Re-arbitrate the same cycle using the new ptr over the current req, with the owner's bit now 0.
    - If there is a winner, load the new grant at the next edge and stay in BUSY (zero-bubble handoff).
    - Otherwise clear outputs and go to IDLE.
- ptr updates only on release (or timeout), never on grant.
- Simultaneous requests in IDLE are resolved by ptr order. After reset, ptr=0 gives requester 0 the highest priority.
- A requester that drops and re-raises req in the same cycle as its release is treated as a new request and is ranked lowest, because ptr has moved past it.
- Invariants: grant is always one-hot or zero; grant_valid == |grant; grant == (1<<grant_idx) whenever grant_valid=1.
- Requests raised in IDLE that drop before the edge are not granted; arbitration samples req only at the edge.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A hold counter (width clog2(MAX_HOLD)+1) clears on each new grant and increments each BUSY cycle.
  - When the counter reaches MAX_HOLD-1 with the owner's req still high, the grant is forcibly released: ptr := grant_idx+1 and re-arbitration excludes the current owner for that cycle.
  - A grant therefore lasts at most MAX_HOLD cycles.
  - The counter resets to 0 on reset_n.
- Not defined:
  - No counter is built.
  - A grant is held indefinitely while its req stays high.

Decomposition:
- Package arb_pkg holds:
  - localparams ARB_N=8 and ARB_IDX_W=3.
  - Enum arb_state_t {IDLE, BUSY}.
  - localparam ARB_MAX_HOLD_DEF=16.
- Sub-module rr_pick (combinational):
  - Rotates req right by ptr.
  - Priority-encodes the lowest set bit into a 3-bit index plus a found flag.
  - Adds ptr back mod 8.
- All flops live in rr_arbiter_8.

Test Plan:
- Reset behaviour: assert reset_n=0 during an active grant to requester 5 → grant, grant_idx and grant_valid go to 0 immediately. After release, req=8'h01 gives grant=8'h01 one cycle later.
- Single requester: req=8'h10 from IDLE → next edge grant=8'h10, grant_idx=4. Held while req[4]=1. Drop req[4] → grant=0 next edge, ptr=5.
- Rotation, simultaneous requests: req=8'hFF held, with each owner dropping its bit for one cycle after 2 cycles of grant → grant_idx sequence 0,1,2,…,7,0 with zero idle cycles between grants.
- Wrap and priority: ptr=6 (after releasing 5), req=8'h81 → grant_idx=7. On its release, ptr=0 → grant_idx=0.
- No preemption: grant on requester 2, raise req[0] and req[1] → grant stays 8'h04 until req[2]=0, then grant_idx=0 (with ptr=3, scanning 3..7 finds nothing, then 0).
- ARB_TIMEOUT_EN, MAX_HOLD=4: req=8'h03 held constantly → grant alternates idx 0,1,0,1, each held exactly 4 cycles. Without the macro → idx 0 held forever.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Holds the requester count, index width, default hold limit used by the
// optional ARB_TIMEOUT_EN build, the FSM state type and a one-hot helper.
package arb_pkg;

    localparam int unsigned ARB_N            = 8;
    localparam int unsigned ARB_IDX_W        = 3;
    localparam int unsigned ARB_MAX_HOLD_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Binary index to one-hot requester vector.
    function automatic logic [ARB_N-1:0] idx_to_onehot(input logic [ARB_IDX_W-1:0] idx);
        return ARB_N'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority picker.
// Finds the first set bit of req scanning ptr, ptr+1, ... ptr+7 (mod 8).
// Ports:
//   req   - candidate request vector
//   ptr   - highest-priority position
//   idx   - winning requester index (0 when none found)
//   found - high when any bit of req is set
module rr_pick
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]     req,
    input  logic [ARB_IDX_W-1:0] ptr,
    output logic [ARB_IDX_W-1:0] idx,
    output logic                 found
);

    logic [ARB_N-1:0]     rot;
    logic [ARB_IDX_W-1:0] off;
    logic                 hit;

    // Rotate right by ptr so bit 0 of rot is the highest-priority requester.
    always_comb begin
        rot = '0;
        for (int i = 0; i < int'(ARB_N); i++) begin
            rot[i] = req[ARB_IDX_W'(ARB_IDX_W'(i) + ptr)];
        end
    end

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        off = '0;
        hit = 1'b0;
        for (int i = 0; i < int'(ARB_N); i++) begin
            if (!hit && rot[i]) begin
                off = ARB_IDX_W'(i);
                hit = 1'b1;
            end
        end
    end

    // Undo the rotation; the 3-bit add wraps mod 8.
    assign idx   = hit ? ARB_IDX_W'(off + ptr) : '0;
    assign found = hit;

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with hold-until-release grants.
// A grant stays with its owner until the owner drops req; priority then
// rotates to the requester after the owner and a new grant is loaded on the
// next edge with no idle bubble.
// Optional build macro: ARB_TIMEOUT_EN -- bounds each grant to MAX_HOLD
// cycles by forcing a release when the owner keeps requesting.
// Ports:
//   clk         - system clock, rising edge
//   reset_n     - asynchronous active-low reset
//   req         - level-sensitive request vector, bit i = requester i
//   grant       - registered one-hot grant, zero when idle
//   grant_idx   - registered binary index of the owner, zero when idle
//   grant_valid - registered, high while any grant is active
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int unsigned N        = ARB_N,
    parameter int unsigned IDX_W    = ARB_IDX_W
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int unsigned MAX_HOLD = ARB_MAX_HOLD_DEF
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     grant_d;
    logic [IDX_W-1:0] idx_d;
    logic             valid_d;

    logic [N-1:0]     pick_req_c;
    logic [IDX_W-1:0] pick_ptr_c;
    logic [IDX_W-1:0] pick_idx_c;
    logic             pick_found_c;
    logic             release_c;
    logic             load_c;
    logic             timeout_c;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD) + 1;

    logic [HOLD_W-1:0] hold_q, hold_d;

    assign timeout_c = (hold_q == HOLD_W'(MAX_HOLD - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // In BUSY the picker already looks ahead with the post-release pointer and
    // with the owner masked out, so a release can hand off in the same cycle.
    always_comb begin
        pick_req_c = req;
        pick_ptr_c = ptr_q;
        if (state_q == BUSY) begin
            pick_req_c = req & ~grant;
            pick_ptr_c = IDX_W'(grant_idx + IDX_W'(1));
        end
    end

    rr_pick u_pick (
        .req   (pick_req_c),
        .ptr   (pick_ptr_c),
        .idx   (pick_idx_c),
        .found (pick_found_c)
    );

    assign release_c = (state_q == BUSY) && (!req[grant_idx] || timeout_c);

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant;
        idx_d   = grant_idx;
        valid_d = grant_valid;
        load_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found_c) begin
                    load_c  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (release_c) begin
                    ptr_d = pick_ptr_c;
                    if (pick_found_c) begin
                        load_c = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        idx_d   = '0;
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                idx_d   = '0;
                valid_d = 1'b0;
            end
        endcase

        if (load_c) begin
            grant_d = idx_to_onehot(pick_idx_c);
            idx_d   = pick_idx_c;
            valid_d = 1'b1;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter: cleared on every new grant, counts cycles of ownership.
    always_comb begin
        hold_d = hold_q;
        if (load_c) begin
            hold_d = '0;
        end else if (state_q == BUSY && !release_c) begin
            hold_d = HOLD_W'(hold_q + HOLD_W'(1));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    // State, pointer and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant       <= grant_d;
            grant_idx   <= idx_d;
            grant_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: a table of single-cycle vectors followed
// by hand-written sequences for reset, rotation, glitch and long-hold cases.
module tb_rr_arbiter_8;

    localparam int HOLD = 16;

    typedef struct {
        logic [7:0] req;
        logic [7:0] grant;
        logic [2:0] idx;
        logic       valid;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;

    int tests;
    int fails;

    vec_t vecs[16];

    rr_arbiter_8 dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] eg,
                         input logic [2:0] ei, input logic ev);
        tests++;
        if (grant !== eg) begin
            fails++;
            $display("FAIL %s grant: got %h want %h", name, grant, eg);
        end
        tests++;
        if (grant_idx !== ei) begin
            fails++;
            $display("FAIL %s grant_idx: got %0d want %0d", name, grant_idx, ei);
        end
        tests++;
        if (grant_valid !== ev) begin
            fails++;
            $display("FAIL %s grant_valid: got %b want %b", name, grant_valid, ev);
        end
    endtask

    // Drive req away from the edge, then sample just after the edge.
    task automatic step(input logic [7:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] one;
        logic [2:0] nxt;
        logic [2:0] exp_idx;

        tests = 0;
        fails = 0;

        // Vectors run back to back from reset (ptr=0, IDLE).
        vecs[0]  = '{8'h00, 8'h00, 3'd0, 1'b0}; // idle
        vecs[1]  = '{8'h10, 8'h10, 3'd4, 1'b1}; // single requester
        vecs[2]  = '{8'h10, 8'h10, 3'd4, 1'b1}; // held
        vecs[3]  = '{8'h00, 8'h00, 3'd0, 1'b0}; // release, ptr=5
        vecs[4]  = '{8'h81, 8'h80, 3'd7, 1'b1}; // ptr=5 -> 7 beats 0
        vecs[5]  = '{8'h01, 8'h01, 3'd0, 1'b1}; // wrap: ptr=0
        vecs[6]  = '{8'h01, 8'h01, 3'd0, 1'b1}; // held
        vecs[7]  = '{8'h07, 8'h01, 3'd0, 1'b1}; // no preemption
        vecs[8]  = '{8'h06, 8'h02, 3'd1, 1'b1}; // handoff to 1
        vecs[9]  = '{8'h05, 8'h04, 3'd2, 1'b1}; // handoff to 2
        vecs[10] = '{8'h07, 8'h04, 3'd2, 1'b1}; // 0,1 raised, no preemption
        vecs[11] = '{8'h03, 8'h01, 3'd0, 1'b1}; // ptr=3 scans 3..7, then 0
        vecs[12] = '{8'h00, 8'h00, 3'd0, 1'b0}; // idle, ptr=1
        vecs[13] = '{8'h24, 8'h04, 3'd2, 1'b1}; // ptr=1 -> 2 before 5
        vecs[14] = '{8'h24, 8'h04, 3'd2, 1'b1}; // held
        vecs[15] = '{8'h20, 8'h20, 3'd5, 1'b1}; // handoff to 5

        req     = 8'h00;
        reset_n = 1'b0;
        #1;
        check("reset", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].req);
            check($sformatf("vec%0d", i), vecs[i].grant, vecs[i].idx, vecs[i].valid);
        end

        // Asynchronous reset while requester 5 owns the grant.
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        step(8'h01);
        check("after_reset", 8'h01, 3'd0, 1'b1);

        // Rotation with all requesting: each owner holds 2 cycles, drops 1.
        @(negedge clk);
        reset_n = 1'b0;
        req     = 8'hFF;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rot_first", 8'h01, 3'd0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            one = 8'h01 << k;
            step(8'hFF);
            check($sformatf("rot_hold%0d", k), one, 3'(k), 1'b1);
            step(8'hFF & ~one);
            nxt = 3'((k + 1) % 8);
            check($sformatf("rot_next%0d", k), 8'h01 << nxt, nxt, 1'b1);
        end

        // Back to idle, then a request that vanishes before the edge.
        step(8'h00);
        check("rot_idle", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        req = 8'h01;
        #2;
        req = 8'h00;
        @(posedge clk);
        #1;
        check("glitch", 8'h00, 3'd0, 1'b0);

        // Long hold by requesters 0 and 1.
        @(negedge clk);
        reset_n = 1'b0;
        req     = 8'h03;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
`ifdef ARB_TIMEOUT_EN
            exp_idx = 3'((c / HOLD) % 2);
`else
            exp_idx = 3'd0;
`endif
            check($sformatf("hold%0d", c), 8'h01 << exp_idx, exp_idx, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
